// File: rtl/cordic_cos.sv
// Fully pipelined CORDIC cosine: IEEE-754 single angle (radians) in, IEEE-754 single cos out.
// One float-to-Q2.30 stage, N_ITER rotation stages, one Q2.30-to-float stage.
module cordic_cos #(
   parameter int unsigned N_ITER = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] fixedpoint_in,
   output logic [31:0] fixedpoint_out,
   output logic [31:0] result
);

   typedef logic signed [31:0] word_t;

   localparam int    NI = int'(N_ITER);
   localparam word_t K  = 32'sh26DD_3B6A;

   // atan(2^-i) in Q2.30, rounded; from i = 10 on it equals 2^-i at this precision
   function automatic word_t atan_lut(input int i);
      case (i)
         0:       atan_lut = 32'sh3243_F6A9;
         1:       atan_lut = 32'sh1DAC_6705;
         2:       atan_lut = 32'sh0FAD_BAFD;
         3:       atan_lut = 32'sh07F5_6EA7;
         4:       atan_lut = 32'sh03FE_AB77;
         5:       atan_lut = 32'sh01FF_D55C;
         6:       atan_lut = 32'sh00FF_FAAB;
         7:       atan_lut = 32'sh007F_FF55;
         8:       atan_lut = 32'sh003F_FFEB;
         9:       atan_lut = 32'sh001F_FFFD;
         default: atan_lut = (i <= 30) ? (word_t'(1) <<< (30 - i)) : '0;
      endcase
   endfunction

   logic unused_datab;
   assign unused_datab = ^datab;

   logic [7:0]  in_exp;
   logic [31:0] in_man;
   logic [31:0] in_mag;
   word_t       fx_in_d, fx_in_q;

   always_comb begin
      in_exp = dataa[30:23];
      in_man = {8'h00, 1'b1, dataa[22:0]};
      if (in_exp == 8'd0) begin
         in_mag = '0;
      end else if (in_exp >= 8'd128) begin
         in_mag = 32'h7FFF_FFFF;
      end else if (in_exp >= 8'd120) begin
         in_mag = in_man << (in_exp - 8'd120);
      end else begin
         in_mag = in_man >> (8'd120 - in_exp);
      end
      fx_in_d = dataa[31] ? -in_mag : in_mag;
   end

   word_t xs [NI];
   word_t ys [NI];
   word_t zs [NI];
   word_t x_d [NI-1];
   word_t y_d [NI-1];
   word_t z_d [NI-1];
   word_t x_q [NI-1];
   word_t y_q [NI-1];
   word_t z_q [NI-1];
   word_t fx_out_d, fx_out_q;

   always_comb begin
      xs[0] = K;
      ys[0] = '0;
      zs[0] = fx_in_q;
      for (int i = 1; i < NI; i++) begin
         xs[i] = x_q[i-1];
         ys[i] = y_q[i-1];
         zs[i] = z_q[i-1];
      end
      for (int i = 0; i < NI - 1; i++) begin
         if (!zs[i][31]) begin
            x_d[i] = xs[i] - (ys[i] >>> i);
            y_d[i] = ys[i] + (xs[i] >>> i);
            z_d[i] = zs[i] - atan_lut(i);
         end else begin
            x_d[i] = xs[i] + (ys[i] >>> i);
            y_d[i] = ys[i] - (xs[i] >>> i);
            z_d[i] = zs[i] + atan_lut(i);
         end
      end
      // Only X is needed out of the last micro-rotation
      if (!zs[NI-1][31]) begin
         fx_out_d = xs[NI-1] - (ys[NI-1] >>> (NI - 1));
      end else begin
         fx_out_d = xs[NI-1] + (ys[NI-1] >>> (NI - 1));
      end
   end

   logic        out_sign;
   logic [31:0] out_mag;
   logic [4:0]  out_lead;
   logic [7:0]  out_exp;
   logic [22:0] out_frac;
   logic [31:0] result_d, result_q;

   always_comb begin
      out_sign = fx_out_q[31];
      out_mag  = out_sign ? -fx_out_q : fx_out_q;
      out_lead = '0;
      for (int j = 0; j < 32; j++) begin
         if (out_mag[j]) out_lead = 5'(j);
      end
      out_frac = 23'((out_mag << (5'd31 - out_lead)) >> 8);
      out_exp  = 8'd97 + {3'b000, out_lead};
      result_d = (out_mag == '0) ? '0 : {out_sign, out_exp, out_frac};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fx_in_q  <= '0;
         fx_out_q <= '0;
         result_q <= '0;
         for (int i = 0; i < NI - 1; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            z_q[i] <= '0;
         end
      end else begin
         fx_in_q  <= fx_in_d;
         fx_out_q <= fx_out_d;
         result_q <= result_d;
         for (int i = 0; i < NI - 1; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
            z_q[i] <= z_d[i];
         end
      end
   end

   assign fixedpoint_in  = fx_in_q;
   assign fixedpoint_out = fx_out_q;
   assign result         = result_q;

endmodule

// File: tb/tb_cordic_cos.sv
// Bench for cordic_cos: directed and random angles, scoreboard keyed on the cycle each
// output is due, plus reset behaviour at start and mid-stream.
module tb_cordic_cos;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic [31:0] fixedpoint_in;
   logic [31:0] fixedpoint_out;
   logic [31:0] result;

   cordic_cos #(.N_ITER(20)) dut (
      .clk           (clk),
      .rst           (rst),
      .dataa         (dataa),
      .datab         (datab),
      .fixedpoint_in (fixedpoint_in),
      .fixedpoint_out(fixedpoint_out),
      .result        (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] a;
      logic [31:0] fx;
      real         c;
      bit          chk;
   } ent_t;

   ent_t fxq[$];
   ent_t resq[$];
   ent_t foq[$];
   int   total = 0;
   int   bad   = 0;
   bit   drain = 1'b0;

   function automatic real f2r(input logic [31:0] b);
      real m;
      if (b[30:23] == 8'd0) return 0.0;
      m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(b[30:23]) - 127.0));
      return b[31] ? -m : m;
   endfunction

   // Q2.30 of the angle, magnitude truncated toward zero, saturated at |x| >= 2
   function automatic logic [31:0] fx_model(input logic [31:0] a);
      logic [31:0] m;
      if (a[30:23] == 8'd0) m = '0;
      else if (a[30:23] >= 8'd128) m = 32'h7FFF_FFFF;
      else m = 32'($rtoi(f2r({1'b0, a[30:0]}) * 1073741824.0));
      return a[31] ? -m : m;
   endfunction

   task automatic drive(input logic [31:0] a, input bit chk);
      ent_t en;
      @(negedge clk);
      dataa  = a;
      datab  = $urandom();
      en.a   = a;
      en.fx  = fx_model(a);
      en.c   = $cos(f2r(a));
      en.chk = chk;
      en.due = cyc + 1;
      fxq.push_back(en);
      if (chk) begin
         en.due = cyc + 22;
         resq.push_back(en);
      end
      if (a == 32'h0) begin
         en.due = cyc + 21;
         foq.push_back(en);
      end
   endtask

   task automatic check3(input string tag);
      total += 3;
      assert (fixedpoint_in === 32'h0) else begin
         bad++;
         $error("FAIL %s fixedpoint_in got=%h exp=00000000", tag, fixedpoint_in);
      end
      assert (fixedpoint_out === 32'h0) else begin
         bad++;
         $error("FAIL %s fixedpoint_out got=%h exp=00000000", tag, fixedpoint_out);
      end
      assert (result === 32'h0) else begin
         bad++;
         $error("FAIL %s result got=%h exp=00000000", tag, result);
      end
   endtask

   always @(negedge clk) begin : mon
      ent_t    en;
      real     got, err;
      bit      ok;
      longint  d;
      if (!rst) begin
         if (fxq.size() > 0 && fxq[0].due == cyc) begin
            en = fxq.pop_front();
            total++;
            assert (fixedpoint_in === en.fx) else begin
               bad++;
               $error("FAIL fx_in a=%h got=%h exp=%h", en.a, fixedpoint_in, en.fx);
            end
         end
         if (foq.size() > 0 && foq[0].due == cyc) begin
            en = foq.pop_front();
            d  = longint'(int'(fixedpoint_out)) - 64'sd1073741824;
            ok = (d <= 16384) && (d >= -16384);
            total++;
            assert (ok === 1'b1) else begin
               bad++;
               $error("FAIL fx_out a=%h got=%h exp=~40000000", en.a, fixedpoint_out);
            end
         end
         if (resq.size() > 0 && resq[0].due == cyc) begin
            en  = resq.pop_front();
            got = f2r(result);
            err = got - en.c;
            if (err < 0.0) err = -err;
            ok  = (err <= 1.0e-5);
            total++;
            assert (ok === 1'b1) else begin
               bad++;
               $error("FAIL result a=%h got=%h (%f) exp=%f", en.a, result, got, en.c);
            end
         end else if (drain) begin
            got = f2r(result) - 1.0;
            if (got < 0.0) got = -got;
            ok  = (result === 32'h0) || (got <= 1.0e-5);
            total++;
            assert (ok === 1'b1) else begin
               bad++;
               $error("FAIL drain result got=%h exp=00000000 or ~3f800000", result);
            end
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      #1 check3("reset_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check3("reset_hold");
      rst = 1'b0;

      drive(32'h3F06_0A92, 1'b1);
      drive(32'hBF06_0A92, 1'b1);
      drive(32'h3E86_0A92, 1'b1);
      drive(32'h0000_0000, 1'b1);
      drive(32'h3F80_0000, 1'b1);
      drive(32'hBF80_0000, 1'b1);
      drive(32'h4000_0000, 1'b0);
      drive(32'hC040_0000, 1'b0);
      drive(32'h7F80_0000, 1'b0);
      drive(32'hFFC0_0000, 1'b0);
      drive(32'h0000_0001, 1'b0);
      drive(32'h3FFF_FFFF, 1'b0);
      drive(32'h3200_0000, 1'b0);
      drive(32'h3FDE_B852, 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive({1'($urandom_range(0, 1)), 8'($urandom_range(112, 126)), 23'($urandom())}, 1'b1);
      end
      repeat (25) @(negedge clk);

      for (int k = 0; k < 8; k++) drive(32'h3F06_0A92, 1'b1);
      #2;
      fxq.delete();
      resq.delete();
      foq.delete();
      rst   = 1'b1;
      dataa = '0;
      #1 check3("reset_mid");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      drain = 1'b1;
      repeat (30) @(negedge clk);
      drain = 1'b0;

      drive(32'h3E86_0A92, 1'b1);
      repeat (25) @(negedge clk);

      total++;
      assert ((fxq.size() + resq.size() + foq.size()) === 0) else begin
         bad++;
         $error("FAIL sb_left got=%0d exp=0", fxq.size() + resq.size() + foq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
